// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and width helpers for the scoreboarded register file.
//   XLEN_DEF / NREGS_DEF / NREAD_DEF : default geometry
//   clog2()                          : ceiling log2 for constant width derivation
//   addr_w()                         : register address width for a given depth
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NREAD_DEF = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int addr_w(input int nregs);
        return (nregs < 2) ? 1 : clog2(nregs);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
//   addr     : register to read
//   regs     : full storage array
//   busy_vec : per-register busy bits
//   we/rd/wdata : writeback this cycle, forwarded to a matching read
//   data     : read value (x0 reads zero, writeback bypassed)
//   hazard   : register has a reservation not satisfied by this cycle's writeback
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_w(NREGS)
) (
    input  logic [AW-1:0]                addr,
    input  logic [NREGS-1:0][XLEN-1:0]   regs,
    input  logic [NREGS-1:0]             busy_vec,
    input  logic                         we,
    input  logic [AW-1:0]                rd,
    input  logic [XLEN-1:0]              wdata,
    output logic [XLEN-1:0]              data,
    output logic                         hazard
);

    logic nonzero;
    logic wr_hit;

    always_comb begin
        nonzero = (addr != '0);
        wr_hit  = we && (rd == addr);
        data    = regs[addr];
        if (wr_hit) data = wdata;
        if (!nonzero) data = '0;
        // The writeback in flight satisfies the reservation, so it is not a hazard.
        hazard  = busy_vec[addr] & ~wr_hit & nonzero;
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass and
// per-register busy bits for RAW hazard detection.
//   clk, rst        : clock, synchronous active-low reset
//   rs_addr/rs_data : NREAD combinational read ports (flattened)
//   rs_busy         : per-port outstanding-reservation flag
//   we/rd/wdata     : writeback; also clears busy[rd]
//   rsv_en/rsv_rd   : reserve a destination (set busy)
//   flush           : clear all busy bits (same-cycle reserve still applies)
//   busy_cnt        : registered count of busy registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int AW    = addr_w(NREGS),
    parameter int CW    = clog2(NREGS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rs_addr,
    output logic [NREAD*XLEN-1:0]   rs_data,
    output logic [NREAD-1:0]        rs_busy,
    input  logic                    we,
    input  logic [AW-1:0]           rd,
    input  logic [XLEN-1:0]         wdata,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_rd,
    input  logic                    flush,
    output logic [CW-1:0]           busy_cnt
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_nxt;
    logic [CW-1:0]              cnt_nxt;
    logic                       wr_clr;
    logic                       rsv_set;
    logic                       cnt_inc;
    logic                       cnt_dec;

    assign wr_clr  = we && (rd != '0);
    assign rsv_set = rsv_en && (rsv_rd != '0);

    // Busy vector and count update. Reserve is applied last so it wins over
    // a same-register writeback and survives a flush.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wr_clr)  busy_nxt[rd]     = 1'b0;
        if (rsv_set) busy_nxt[rsv_rd] = 1'b1;

        cnt_inc = rsv_set && !busy[rsv_rd];
        // A cleared bit that is re-reserved the same cycle nets to no change.
        cnt_dec = wr_clr && busy[rd] && !(rsv_set && (rsv_rd == rd));

        if (flush)
            cnt_nxt = rsv_set ? CW'(1) : '0;
        else
            cnt_nxt = busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs     <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_clr) regs[rd] <= wdata;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rport
        rf_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rport (
            .addr     (rs_addr[p*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy),
            .we       (we),
            .rd       (rd),
            .wdata    (wdata),
            .data     (rs_data[p*XLEN +: XLEN]),
            .hazard   (rs_busy[p])
        );
    end

endmodule
